// File: rtl/chan_arb_pkg.sv
// Shared definitions for the channel arbiter/mux: mode encodings and a
// one-hot to index conversion used to recover the granted channel number.
package chan_arb_pkg;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_FIX = 1'b1;

   // Upper bounds for the generic one-hot conversion; callers zero-extend
   // their grant vector and truncate the returned index to their own width.
   localparam int MAX_CH    = 256;
   localparam int MAX_SEL_W = 8;

   // OR together the indices of all set bits; for a one-hot input this is
   // the position of the single set bit, for an all-zero input it is 0.
   function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
      logic [MAX_SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_SEL_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search starting after ptr, or a fixed
// channel select. Grant is one-hot or all zero.
module rr_arbiter
   import chan_arb_pkg::*;
#(
   parameter  int N_CH  = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             mode,
   input  logic [SEL_W-1:0] fix_sel,
   output logic [N_CH-1:0]  grant
);

   logic found;
   int   idx;

   // Grant selection; the fixed path compares against every legal index so
   // an out-of-range fix_sel simply matches nothing.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      if (mode == MODE_RR) begin
         for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!found && req[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if ((int'(fix_sel) == i) && req[i]) begin
               grant[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/chan_arb_mux.sv
// N-channel arbitrated multiplexer with valid/ready handshakes and a single
// registered output stage. No skid buffer: out_ready feeds in_ready
// combinationally so a drained register can be refilled in the same cycle.
module chan_arb_mux
   import chan_arb_pkg::*;
#(
   parameter  int N_CH  = 8,
   parameter  int WIDTH = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        fix_sel,
   input  logic [N_CH-1:0]         in_valid,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   output logic [N_CH-1:0]         in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   input  logic                    out_ready
);

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0]     out_ch_q,    out_ch_d;
   logic [SEL_W-1:0]     ptr_q,       ptr_d;

   logic                 load;
   logic                 xfer;
   logic [N_CH-1:0]      grant;
   logic [SEL_W-1:0]     grant_idx;
   logic [WIDTH-1:0]     sel_data;
   logic [WIDTH-1:0]     masked [N_CH];

   rr_arbiter #(
      .N_CH    (N_CH)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .mode    (mode),
      .fix_sel (fix_sel),
      .grant   (grant)
   );

   // The register may take a new word when empty or when being drained.
   assign load      = !out_valid_q || out_ready;
   // Gating with rst_n keeps in_ready low while reset is held.
   assign in_ready  = grant & {N_CH{load & rst_n}};
   assign xfer      = |in_ready;
   assign grant_idx = SEL_W'(onehot_to_idx(MAX_CH'(grant)));

   // Per-channel masking stage of the AND-OR data select.
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_mask
         assign masked[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
      end
   endgenerate

   // OR reduction of the masked slices; at most one slice is non-zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         sel_data = sel_data | masked[i];
      end
   end

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
            ptr_d       = grant_idx;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers; ptr resets to the last channel so the first search
   // begins at channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= SEL_W'(N_CH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: doc/chan_arb_mux.md
# chan_arb_mux

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered output stage. Generalises the team's fixed 8:1 decoder-selected mux: it adds per-channel valid/ready handshakes, round-robin or fixed-select arbitration, and a one-cycle registered output carrying the granted data and channel index. Selection is decoded one-hot and combined with an AND-OR network, so no tristate nets are used. The block sits between multiple producer channels and a single shared downstream consumer.

## Interface
Parameters:
- N_CH, 8, number of input channels (≥2)
- WIDTH, 8, data bits per channel
- SEL_W, $clog2(N_CH), channel index width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- mode  input  1  0 = round-robin, 1 = fixed select
- fix_sel  input  SEL_W  channel selected when mode=1
- in_valid  input  N_CH  per-channel data valid
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N_CH  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds data
- out_data  output  WIDTH  granted data
- out_ch  output  SEL_W  index of channel that supplied out_data
- out_ready  input  1  downstream accept

## Operation
- Load condition: load = !out_valid || out_ready.
- Grant (combinational, one-hot or zero):
  - mode=0: first i with in_valid[i] set, searching circularly from ptr+1 through ptr.
  - mode=1: grant fix_sel if in_valid[fix_sel]; otherwise no grant. If fix_sel ≥ N_CH, never grant.
- in_ready = grant & {N_CH{load}}. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - ptr <= g (updated in both modes)
- If load is true with no grant: out_valid <= 0. out_data and out_ch hold their values.
- If load is false: all output registers hold.
- Fairness, mode=0: a channel that holds in_valid high is granted within N_CH transfers.
- Mode changes between cycles are legal and take effect on the next grant evaluation. ptr is not reset by a mode change.
- Producers must hold in_data stable while in_valid is high and in_ready is low.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=N_CH-1 (so the first round-robin search starts at channel 0). in_ready is 0 while in reset.
- Latency: an input accepted at edge k appears on out_valid/out_data after edge k.
- Throughput: one transfer per cycle while out_ready=1.
- Combinational path from out_ready to in_ready is permitted and documented; there is no skid buffer.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and outputs are stable.
- Simultaneous events: out_ready=1 and a new grant in the same cycle gives a back-to-back transfer with no bubble.
- Reset asserted mid-transfer: outputs clear asynchronously and the in-flight word is dropped. After release, the first grant search starts at channel 0.
- All in_valid=0: no grant, and out_valid falls after the consumer drains the register.

## Structure
- Shared package chan_arb_pkg holds:
  - the mode encoding constants MODE_RR=1'b0 and MODE_FIX=1'b1
  - a function that converts a one-hot vector to an index
- One sub-module, rr_arbiter:
  - parameters N_CH
  - inputs: req, ptr, mode, fix_sel
  - output: one-hot grant
- Data select: an AND-OR reduction over in_data slices masked by grant, instantiated in the top level.

## Test plan
- Reset then idle: rst_n low for 3 cycles with all in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout.
- Round-robin sweep: mode=0, N_CH=8, all in_valid=1, in_data[i]=8'hA0+i, out_ready=1 -> out_ch sequence 0,1,…,7,0, out_data matching, one word per cycle.
- Sparse round-robin: valid only on channels 2 and 5, out_ready=1 -> out_ch alternates 2,5,2,5; in_ready[2] and in_ready[5] are never high in the same cycle.
- Fixed select plus backpressure: mode=1, fix_sel=3, in_data[3]=8'h5C, out_ready=0 for 4 cycles -> one word is captured, then in_ready=0 and out_data=8'h5C stable; after out_ready=1 the next word is accepted in the same cycle.
- Out-of-range fixed select: N_CH=6, mode=1, fix_sel=7, all valid -> no in_ready, and out_valid stays 0.
- Reset mid-stream: assert rst_n low during round-robin traffic at out_ch=4 -> outputs are 0 immediately; after release the first grant is channel 0.
